// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state enum, default timing and sizing helper for the button conditioner
package btn_pkg;

    // Per-channel debounce / hold state
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } btn_state_e;

    // Default timing, in clock cycles
    localparam int DEF_DEBOUNCE_CYC  = 16;
    localparam int DEF_REPEAT_DELAY  = 25000000;
    localparam int DEF_REPEAT_PERIOD = 5000000;

    // Counter width for a count limit; never narrower than one bit
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    // Larger of two widths
    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one key channel: synchronizer, debounce FSM and auto-repeat counter
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    input  logic repeat_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int RW = max_width(cnt_width(REPEAT_DELAY), cnt_width(REPEAT_PERIOD));

    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [DW-1:0] DEB_MAX     = '1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [RW-1:0] REP_MAX     = '1;

    // Synchronizer stages hold the pressed sense (1 = pressed), so reset means released
    logic sync1_q, sync2_q;
    logic pressed;

    btn_state_e state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    // Set while waiting for the first repeat after a fresh press
    logic rep_first_q, rep_first_d;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic [RW-1:0] rep_last;

    assign pressed  = sync2_q;
    assign rep_last = rep_first_q ? DELAY_LAST : PERIOD_LAST;

    // Two-flop synchronizer on the raw key, inverted on entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~key_ni;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
        end
    end

    // Next-state, counter and pulse decode
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        press_d     = 1'b0;
        release_d   = 1'b0;

        case (state_q)
            IDLE: begin
                deb_cnt_d = '0;
                if (pressed) begin
                    state_d = DEB_PRESS;
                end
            end

            DEB_PRESS: begin
                if (!pressed) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    deb_cnt_d   = '0;
                    press_d     = 1'b1;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end else if (deb_cnt_q != DEB_MAX) begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end

            HELD: begin
                deb_cnt_d = '0;
                if (!pressed) begin
                    // Repeat counter freezes while the release is being qualified
                    state_d = DEB_REL;
                end else if (repeat_en_i) begin
                    if (rep_cnt_q == rep_last) begin
                        press_d     = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else if (rep_cnt_q != REP_MAX) begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
                end
            end

            DEB_REL: begin
                if (pressed) begin
                    // Bounce back to held: restart the repeat period, no pulse
                    state_d     = HELD;
                    deb_cnt_d   = '0;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                    release_d = 1'b1;
                end else if (deb_cnt_q != DEB_MAX) begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end
        endcase

        // Dropping the enable in any cycle restarts the initial repeat delay
        if (!repeat_en_i) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end

        level_d = (state_d == HELD) || (state_d == DEB_REL);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_CH independent debounced keys with auto-repeat
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] key_ni,
    input  logic [N_CH-1:0] repeat_en_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o
);

    // One fully independent conditioner per key
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .key_ni      (key_ni[i]),
            .repeat_en_i (repeat_en_i[i]),
            .level_o     (level_o[i]),
            .press_o     (press_o[i]),
            .release_o   (release_o[i])
        );
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_CH, 2, number of independent key channels (1..16).
REQ-002 Parameter DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a level change (>=2).
REQ-003 Parameter REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat pulse (>=2).
REQ-004 Parameter REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses (>=2).
REQ-005 Clk  input  1  system clock, all state on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Key_n  input  N_CH  raw asynchronous keys, active-low (0 = pressed).
REQ-008 Repeat_en  input  N_CH  per-channel auto-repeat enable, synchronous to Clk.
REQ-009 Level  output  N_CH  debounced key state, active-high (1 = pressed).
REQ-010 Press  output  N_CH  one-cycle pulse on accepted press and on each auto-repeat.
REQ-011 Release  output  N_CH  one-cycle pulse on accepted release.

Function
REQ-012 Each Key_n bit SHALL pass through a two-flop synchronizer; downstream logic uses only the inverted synchronized value (pressed = 1).
REQ-013 Each channel SHALL run an FSM: IDLE, DEB_PRESS, HELD, DEB_REL.
REQ-014 IDLE -> DEB_PRESS when synchronized pressed = 1; debounce counter cleared.
REQ-015 DEB_PRESS: counter increments each cycle pressed = 1; returns to IDLE with counter cleared on any cycle pressed = 0.
REQ-016 DEB_PRESS -> HELD when the counter reaches DEBOUNCE_CYC-1 with pressed = 1; Level rises and Press pulses in the cycle HELD is entered.
REQ-017 HELD -> DEB_REL when pressed = 0; DEB_REL mirrors DEB_PRESS with polarity inverted, bouncing back to HELD with no pulse.
REQ-018 DEB_REL -> IDLE after DEBOUNCE_CYC consecutive pressed = 0 cycles; Level falls and Release pulses in the cycle IDLE is entered.
REQ-019 Latency: with Key_n stable, Level changes exactly 2+DEBOUNCE_CYC rising edges after the first edge sampling the new Key_n value.
REQ-020 In HELD with Repeat_en[i] = 1, a repeat counter SHALL issue a Press pulse REPEAT_DELAY cycles after HELD entry, then every REPEAT_PERIOD cycles.
REQ-021 Repeat_en[i] = 0 in any cycle SHALL clear the repeat counter; re-assertion while HELD restarts the REPEAT_DELAY interval.
REQ-022 Repeat counter SHALL freeze (no pulses) in DEB_REL and reset on re-entry to HELD from DEB_REL, restarting REPEAT_PERIOD (not REPEAT_DELAY).
REQ-023 Press and Release SHALL never both be 1 in the same cycle on one channel; Press SHALL never be asserted for two consecutive cycles.
REQ-024 Channels SHALL be fully independent; simultaneous events on different channels produce simultaneous pulses.
REQ-025 Counters SHALL be sized $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-026 Reset = 0 SHALL asynchronously force all FSMs to IDLE, all counters and synchronizer flops to 0 (pressed = 0), and Level, Press, Release to 0.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL discard the partial count; after release a held key requires a full 2+DEBOUNCE_CYC cycles and produces one Press.

Structure
REQ-028 Shared package btn_pkg SHALL hold the channel state enum (IDLE, DEB_PRESS, HELD, DEB_REL) and default values of DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD.
REQ-029 One sub-module btn_channel (single-channel synchronizer, FSM, counters) SHALL be instantiated N_CH times by a generate loop.

Verification (N_CH=2, DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-030 Key_n[0] 1->0 stable -> Level[0] rises and Press[0] pulses once, 6 edges after first sampling edge; Release[0] 0 throughout.
REQ-031 Key_n[0] low 3 cycles then high (bounce) -> Level, Press, Release stay 0; FSM back in IDLE.
REQ-032 Repeat_en[1]=1, Key_n[1] held low 30 cycles after acceptance -> Press[1] at +0, +10, +15, +20, +25, +30.
REQ-033 Key held, Release-side bounce high 2 cycles then low -> no Release pulse, Level stays 1; final release gives one Release 6 edges later.
REQ-034 Reset pulsed low mid-DEB_PRESS with key held -> outputs 0 immediately; exactly one Press 6 edges after Reset returns high.
REQ-035 Both keys pressed same cycle, Repeat_en=2'b00 -> Press=2'b11 for one cycle, no further pulses while held.
